fifo_fwft_reader: RTL and testbench

- Read-side consumer for the team's async FIFO. Sits in the read clock domain next to rd_ptr_ctrl and the FIFO RAM.
- Drives the FIFO's standard-mode read port (rd_en/empty, data one cycle after rd_en).
- Re-presents the data as a first-word-fall-through valid/ready stream.
- Holds a 2-entry output buffer so downstream back-pressure never loses words and full throughput is sustained.

---
 rtl/fifo_fwft_reader.sv | 50 +++++
 tb/tb_fifo_fwft_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_reader.sv
// fifo_fwft_reader: turns a standard-mode FIFO read port into a first-word-fall-through valid/ready stream
module fifo_fwft_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occ,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  logic                  inflight, head, tail, pop, head_nx;
  logic [1:0]            occ_nx;
  logic [DATA_WIDTH-1:0] mem [2];
  // occ + inflight never exceeds 2 and pop implies occ >= 1, so 2 bits cannot wrap
  always_comb begin
    pop = m_valid & m_ready;
    occ_nx = occ + {1'b0, inflight} - {1'b0, pop};
    fifo_rd_en = !rst & !fifo_empty & (occ_nx < 2'd2);
    head_nx = head ^ pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      inflight <= 1'b0;
      head <= 1'b0;
      tail <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      rd_count <= '0;
    end else begin
      occ <= occ_nx;
      inflight <= fifo_rd_en;
      head <= head_nx;
      if (inflight) begin
        mem[tail] <= fifo_rd_data;
        tail <= ~tail;
      end
      m_valid <= occ_nx != 2'd0;
      // the word landing this cycle becomes the head only when it fills the slot head moves to
      m_data <= (inflight && tail == head_nx) ? fifo_rd_data : mem[head_nx];
      rd_count <= rd_count + CNT_WIDTH'(pop);
    end
  end
endmodule

// File: tb/tb_fifo_fwft_reader.sv
// tb_fifo_fwft_reader: directed and random checks of the FWFT reader against a FIFO model and an in-order scoreboard
module tb_fifo_fwft_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en, rd_en4, m_valid, m_valid4, m_ready = 1'b0;
  logic [7:0] fifo_rd_data = '0;
  logic [7:0] m_data, m_data4;
  logic [1:0] occ, occ4;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;
  logic [7:0] fmem [256];
  int wr_ptr = 0, rd_ptr = 0;
  int n_chk = 0, n_pass = 0;
  int reads = 0, pops = 0, cnt = 0, exp_idx = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  always #5 clk = ~clk;

  fifo_fwft_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occ(occ), .rd_count(rd_count)
  );

  fifo_fwft_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .occ(occ4), .rd_count(rd_count4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr % 256] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // FIFO read side: registered empty flag, data one cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    if (fifo_rd_en) fifo_rd_data <= fmem[rd_ptr % 256];
    else fifo_rd_data <= 8'($urandom);
    rd_ptr <= rd_ptr + (fifo_rd_en ? 1 : 0);
    fifo_empty <= (wr_ptr == rd_ptr + (fifo_rd_en ? 1 : 0));
  end

  // scoreboard: every pop must deliver the next word read from the FIFO since the last reset
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rd_en", fifo_rd_en, 0);
      reads = 0;
      pops = 0;
      cnt = 0;
      exp_idx = rd_ptr;
      pv = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_while_empty", fifo_empty, 0);
        reads++;
      end
      check("rd_count", rd_count, cnt & 16'hffff);
      check("rd_count4", rd_count4, cnt % 16);
      check("valid_vs_occ", m_valid, occ != 2'd0);
      check("occ_le2", occ <= 2'd2, 1);
      if (pv && !pr) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, pd);
      end
      if (m_valid && m_ready) begin
        check("order", m_data, fmem[exp_idx % 256]);
        exp_idx++;
        pops++;
        cnt++;
      end
      check("outstanding_le2", (reads - pops) <= 2, 1);
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  initial begin
    // 1: preloaded burst with m_ready high
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
    do_reset();
    @(negedge clk);
    check("t1_first_rd_en", fifo_rd_en, 1);
    check("rst_occ", occ, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_count", rd_count, 0);
    tick();
    @(negedge clk);
    check("t1_valid_early", m_valid, 0);
    tick();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t1_valid", m_valid, 1);
      check("t1_data", m_data, 8'h10 + 8'(i));
      tick();
      @(negedge clk);
    end
    check("t1_valid_end", m_valid, 0);
    check("t1_count", rd_count, 10);
    // 2: back-pressure
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    do_reset();
    repeat (20) tick();
    @(negedge clk);
    check("t2_reads", reads, 2);
    check("t2_occ", occ, 2);
    check("t2_valid", m_valid, 1);
    check("t2_data", m_data, 8'h20);
    tick();
    m_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("t2_pops", pops, 5);
    check("t2_occ_end", occ, 0);
    check("t2_count", rd_count, 5);
    // 3: m_ready toggling
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    do_reset();
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("t3_pops", pops, 10);
    check("t3_count", rd_count, 10);
    // 4: single word latency
    do_reset();
    repeat (3) tick();
    @(negedge clk);
    check("t4_idle_rd_en", fifo_rd_en, 0);
    check("t4_idle_valid", m_valid, 0);
    tick();
    push(8'ha5);
    @(negedge clk);
    check("t4_W_rd_en", fifo_rd_en, 0);
    tick();
    @(negedge clk);
    check("t4_T_rd_en", fifo_rd_en, 1);
    tick();
    @(negedge clk);
    check("t4_T1_rd_en", fifo_rd_en, 0);
    check("t4_T1_valid", m_valid, 0);
    tick();
    @(negedge clk);
    check("t4_T2_valid", m_valid, 1);
    check("t4_T2_data", m_data, 8'ha5);
    tick();
    @(negedge clk);
    check("t4_T3_valid", m_valid, 0);
    // 5: reset mid-stream discards buffered and in-flight words
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
    do_reset();
    repeat (5) tick();
    @(negedge clk);
    check("t5_pre_occ", occ, 1);
    check("t5_pre_count", rd_count, 3);
    check("t5_pre_rd_en", fifo_rd_en, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_occ", occ, 0);
    check("t5_valid", m_valid, 0);
    check("t5_count", rd_count, 0);
    repeat (2) tick();
    @(negedge clk);
    check("t5_resume_valid", m_valid, 1);
    check("t5_resume_data", m_data, 8'h46);
    repeat (10) tick();
    @(negedge clk);
    check("t5_pops", pops, 6);
    check("t5_count_end", rd_count, 6);
    // 6: 4-bit counter wrap
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    do_reset();
    repeat (22) tick();
    @(negedge clk);
    check("t6_count16", rd_count, 17);
    check("t6_count4", rd_count4, 1);
    // 7: random traffic and back-pressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1 && wr_ptr - rd_ptr < 200) push(8'($urandom));
      m_ready = $urandom_range(3, 0) != 0;
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 500 && !(exp_idx == wr_ptr && !m_valid); i++) tick();
    @(negedge clk);
    check("t7_drained", exp_idx, wr_ptr);
    check("t7_valid_end", m_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
